// File: rtl/inst_prefetch_buffer_pkg.sv
// ---------------------------------------------------------------------------
// inst_prefetch_buffer_pkg : shared types and constants for the fetch queue
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package inst_prefetch_buffer_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc_plus4;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/inst_prefetch_buffer_fifo.sv
// ---------------------------------------------------------------------------
// prefetch_fifo : synchronous DEPTH-entry queue of fetched instructions
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module prefetch_fifo
  import inst_prefetch_buffer_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush_i,
  input  logic               wr_en_i,
  input  logic [ENTRY_W-1:0] wr_data_i,
  input  logic               rd_en_i,
  output logic [ENTRY_W-1:0] head_o,
  output logic [CW-1:0]      count_o
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               w_wr;
  logic               w_rd;

  assign w_wr = wr_en_i && !flush_i && (count_q != CW'(DEPTH));
  assign w_rd = rd_en_i && !flush_i && (count_q != '0);

  // Pointers wrap for free because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_wr) wr_ptr_d = wr_ptr_q + 1'b1;
      if (w_rd) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(w_wr) - CW'(w_rd);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/inst_prefetch_buffer.sv
// ---------------------------------------------------------------------------
// inst_prefetch_buffer : single-outstanding instruction prefetcher with redirect
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module inst_prefetch_buffer
  import inst_prefetch_buffer_pkg::*;
#(
  parameter  int          DEPTH    = 4,
  parameter  logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  localparam int          CW       = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  input  logic          stall_d,
  output logic          imem_req,
  output logic [31:0]   imem_addr,
  input  logic          imem_ready,
  input  logic          imem_rvalid,
  input  logic [31:0]   imem_rdata,
  output logic          instr_valid,
  output logic [31:0]   instr_out,
  output logic [31:0]   pc_plus4_out,
  output logic [CW-1:0] fifo_count
);

  fetch_state_t       state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic               w_outstanding;
  logic [CW:0]        w_occupancy;
  logic               w_accept;
  logic               w_enq;
  logic               w_deq;
  logic               w_valid;
  logic [CW-1:0]      w_count;
  logic [ENTRY_W-1:0] w_head_raw;
  fetch_entry_t       w_head;
  fetch_entry_t       w_wr_entry;

  assign w_outstanding = (state_q != ST_IDLE);
  assign w_occupancy   = {1'b0, w_count} + {{CW{1'b0}}, w_outstanding};
  assign w_valid       = (w_count != '0);

  // A new request may overlap the response of the previous one, never a dropped one.
  assign imem_req = !reset && !redirect_valid
                 && ((state_q == ST_IDLE) || ((state_q == ST_WAIT) && imem_rvalid))
                 && (w_occupancy < (CW + 1)'(DEPTH));
  assign imem_addr = fetch_pc_q;
  assign w_accept  = imem_req && imem_ready;

  assign w_enq = imem_rvalid && (state_q == ST_WAIT) && !redirect_valid;
  assign w_deq = w_valid && !stall_d && !redirect_valid;

  // While in WAIT, fetch_pc_q already holds the outstanding address + 4.
  assign w_wr_entry = '{pc_plus4: fetch_pc_q, instr: imem_rdata};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      if (w_outstanding && !imem_rvalid) state_d = ST_DISCARD;
      else                               state_d = ST_IDLE;
    end else if (w_accept) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
      state_d    = ST_WAIT;
    end else if (w_outstanding && imem_rvalid) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  prefetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush_i   (redirect_valid),
    .wr_en_i   (w_enq),
    .wr_data_i (w_wr_entry),
    .rd_en_i   (w_deq),
    .head_o    (w_head_raw),
    .count_o   (w_count)
  );

  assign w_head       = w_head_raw;
  assign instr_valid  = w_valid;
  assign instr_out    = w_valid ? w_head.instr    : NOP_INSTR;
  assign pc_plus4_out = w_valid ? w_head.pc_plus4 : NOP_INSTR;
  assign fifo_count   = w_count;

endmodule

`default_nettype wire

// File: tb/tb_inst_prefetch_buffer.sv
// ---------------------------------------------------------------------------
// tb_inst_prefetch_buffer : directed self-checking bench for the prefetcher
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_inst_prefetch_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        stall_d = 1'b0;
  logic        imem_ready = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;

  logic        imem_req, imem_req_b;
  logic [31:0] imem_addr, imem_addr_b;
  logic        instr_valid, instr_valid_b;
  logic [31:0] instr_out, instr_out_b;
  logic [31:0] pc_plus4_out, pc_plus4_out_b;
  logic [2:0]  fifo_count, fifo_count_b;

  int total  = 0;
  int passed = 0;
  bit auto_mem = 1'b1;
  bit use_b = 1'b0;

  always #5 clk = ~clk;

  inst_prefetch_buffer dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall_d(stall_d), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr_out(instr_out), .pc_plus4_out(pc_plus4_out), .fifo_count(fifo_count)
  );

  inst_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_b (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall_d(stall_d), .imem_req(imem_req_b), .imem_addr(imem_addr_b), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr_valid(instr_valid_b),
    .instr_out(instr_out_b), .pc_plus4_out(pc_plus4_out_b), .fifo_count(fifo_count_b)
  );

  // Memory with one-cycle latency; instruction word = address ^ 32'h13579BDF.
  task automatic cycle();
    logic        acc;
    logic [31:0] a;
    #1;
    acc = use_b ? (imem_req_b && imem_ready) : (imem_req && imem_ready);
    a   = use_b ? imem_addr_b : imem_addr;
    @(posedge clk); #1;
    imem_rvalid = auto_mem && acc;
    imem_rdata  = (auto_mem && acc) ? (a ^ 32'h1357_9BDF) : 32'h0;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; stall_d = 1'b0;
    imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0; auto_mem = 1'b1; use_b = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    total++; if (instr_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", instr_valid); else passed++;
    total++; if (fifo_count !== 3'd0) $display("FAIL rst_count: got %0d want 0", fifo_count); else passed++;
    total++; if (imem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", imem_req); else passed++;
    total++; if (pc_plus4_out !== 32'h0) $display("FAIL rst_pc4: got %h want 0", pc_plus4_out); else passed++;
    do_reset();
    total++; if (imem_req !== 1'b1) $display("FAIL rst_first_req: got %b want 1", imem_req); else passed++;
    total++; if (imem_addr !== 32'h0) $display("FAIL rst_first_addr: got %h want 0", imem_addr); else passed++;
    total++; if (instr_out !== 32'h0) $display("FAIL rst_instr: got %h want 0", instr_out); else passed++;
  endtask

  task automatic test_stream();
    do_reset();
    cycle();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) $display("FAIL stream_req4: got %b/%h want 1/00000004", imem_req, imem_addr); else passed++;
    total++; if (instr_valid !== 1'b0) $display("FAIL stream_latency: got %b want 0", instr_valid); else passed++;
    cycle();
    total++; if (instr_valid !== 1'b1 || pc_plus4_out !== 32'h4) $display("FAIL stream_head0: got %b/%h want 1/00000004", instr_valid, pc_plus4_out); else passed++;
    total++; if (instr_out !== 32'h1357_9BDF) $display("FAIL stream_instr0: got %h want 13579bdf", instr_out); else passed++;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) $display("FAIL stream_req8: got %b/%h want 1/00000008", imem_req, imem_addr); else passed++;
    cycle();
    total++; if (pc_plus4_out !== 32'h8 || instr_out !== 32'h1357_9BDB) $display("FAIL stream_head1: got %h/%h want 00000008/13579bdb", pc_plus4_out, instr_out); else passed++;
    cycle();
    total++; if (pc_plus4_out !== 32'hC || fifo_count !== 3'd1) $display("FAIL stream_head2: got %h/%0d want 0000000c/1", pc_plus4_out, fifo_count); else passed++;
  endtask

  task automatic test_stall();
    logic [31:0] exp_pc [4];
    exp_pc = '{32'h4, 32'h8, 32'hC, 32'h10};
    do_reset();
    stall_d = 1'b1;
    repeat (10) cycle();
    total++; if (fifo_count !== 3'd4) $display("FAIL stall_count: got %0d want 4", fifo_count); else passed++;
    total++; if (imem_req !== 1'b0) $display("FAIL stall_req: got %b want 0", imem_req); else passed++;
    total++; if (instr_valid !== 1'b1 || pc_plus4_out !== 32'h4) $display("FAIL stall_head: got %b/%h want 1/00000004", instr_valid, pc_plus4_out); else passed++;
    stall_d = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (instr_valid !== 1'b1 || pc_plus4_out !== exp_pc[i])
        $display("FAIL stall_drain%0d: got %b/%h want 1/%h", i, instr_valid, pc_plus4_out, exp_pc[i]);
      else passed++;
      cycle();
    end
  endtask

  task automatic test_redirect();
    do_reset();
    cycle();
    cycle();
    auto_mem = 1'b0;
    cycle();
    total++; if (imem_req !== 1'b0) $display("FAIL redir_wait_req: got %b want 0", imem_req); else passed++;
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    #1;
    total++; if (imem_req !== 1'b0) $display("FAIL redir_suppress: got %b want 0", imem_req); else passed++;
    cycle();
    redirect_valid = 1'b0;
    #1;
    total++; if (instr_valid !== 1'b0 || fifo_count !== 3'd0) $display("FAIL redir_flush: got %b/%0d want 0/0", instr_valid, fifo_count); else passed++;
    total++; if (imem_req !== 1'b0) $display("FAIL redir_discard_req: got %b want 0", imem_req); else passed++;
    cycle();
    cycle();
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #1;
    total++; if (imem_req !== 1'b0) $display("FAIL redir_drop_req: got %b want 0", imem_req); else passed++;
    cycle();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) $display("FAIL redir_newreq: got %b/%h want 1/00000100", imem_req, imem_addr); else passed++;
    total++; if (instr_valid !== 1'b0) $display("FAIL redir_dropped: got %b want 0", instr_valid); else passed++;
    auto_mem = 1'b1;
    cycle();
    cycle();
    total++; if (instr_valid !== 1'b1 || pc_plus4_out !== 32'h104) $display("FAIL redir_target: got %b/%h want 1/00000104", instr_valid, pc_plus4_out); else passed++;
    total++; if (instr_out !== 32'h1357_9ADF) $display("FAIL redir_instr: got %h want 13579adf", instr_out); else passed++;
  endtask

  task automatic test_collide();
    do_reset();
    cycle();
    cycle();
    total++; if (instr_valid !== 1'b1 || imem_rvalid !== 1'b1) $display("FAIL coll_setup: got %b/%b want 1/1", instr_valid, imem_rvalid); else passed++;
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    #1;
    total++; if (imem_req !== 1'b0) $display("FAIL coll_suppress: got %b want 0", imem_req); else passed++;
    cycle();
    redirect_valid = 1'b0;
    #1;
    total++; if (fifo_count !== 3'd0 || instr_valid !== 1'b0) $display("FAIL coll_flush: got %0d/%b want 0/0", fifo_count, instr_valid); else passed++;
    total++; if (instr_out !== 32'h0 || pc_plus4_out !== 32'h0) $display("FAIL coll_nop: got %h/%h want 0/0", instr_out, pc_plus4_out); else passed++;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) $display("FAIL coll_req: got %b/%h want 1/00000200", imem_req, imem_addr); else passed++;
    cycle();
    cycle();
    total++; if (instr_valid !== 1'b1 || pc_plus4_out !== 32'h204) $display("FAIL coll_target: got %b/%h want 1/00000204", instr_valid, pc_plus4_out); else passed++;
  endtask

  task automatic test_wrap();
    do_reset();
    use_b = 1'b1;
    total++; if (imem_req_b !== 1'b1 || imem_addr_b !== 32'hFFFF_FFF8) $display("FAIL wrap_req0: got %b/%h want 1/fffffff8", imem_req_b, imem_addr_b); else passed++;
    cycle();
    total++; if (imem_addr_b !== 32'hFFFF_FFFC) $display("FAIL wrap_req1: got %h want fffffffc", imem_addr_b); else passed++;
    cycle();
    total++; if (imem_addr_b !== 32'h0) $display("FAIL wrap_req2: got %h want 00000000", imem_addr_b); else passed++;
    total++; if (instr_valid_b !== 1'b1 || pc_plus4_out_b !== 32'hFFFF_FFFC) $display("FAIL wrap_head0: got %b/%h want 1/fffffffc", instr_valid_b, pc_plus4_out_b); else passed++;
    total++; if (instr_out_b !== 32'hECA8_6427) $display("FAIL wrap_instr0: got %h want eca86427", instr_out_b); else passed++;
    cycle();
    total++; if (instr_valid_b !== 1'b1 || pc_plus4_out_b !== 32'h0) $display("FAIL wrap_head1: got %b/%h want 1/00000000", instr_valid_b, pc_plus4_out_b); else passed++;
    cycle();
    total++; if (instr_valid_b !== 1'b1 || pc_plus4_out_b !== 32'h4) $display("FAIL wrap_head2: got %b/%h want 1/00000004", instr_valid_b, pc_plus4_out_b); else passed++;
    use_b = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    stall_d = 1'b1;
    cycle();
    cycle();
    auto_mem = 1'b0;
    cycle();
    total++; if (fifo_count !== 3'd2 || instr_valid !== 1'b1) $display("FAIL rmid_setup: got %0d/%b want 2/1", fifo_count, instr_valid); else passed++;
    #2;
    reset = 1'b1;
    #1;
    total++; if (instr_valid !== 1'b0 || fifo_count !== 3'd0) $display("FAIL rmid_async: got %b/%0d want 0/0", instr_valid, fifo_count); else passed++;
    total++; if (instr_out !== 32'h0 || pc_plus4_out !== 32'h0 || imem_req !== 1'b0) $display("FAIL rmid_outs: got %h/%h/%b want 0/0/0", instr_out, pc_plus4_out, imem_req); else passed++;
    @(posedge clk); #1;
    reset = 1'b0; stall_d = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    #1;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL rmid_req: got %b/%h want 1/00000000", imem_req, imem_addr); else passed++;
    cycle();
    total++; if (instr_valid !== 1'b0 || fifo_count !== 3'd0) $display("FAIL rmid_stray: got %b/%0d want 0/0", instr_valid, fifo_count); else passed++;
    cycle();
    total++; if (instr_valid !== 1'b0) $display("FAIL rmid_stray2: got %b want 0", instr_valid); else passed++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_collide();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/inst_prefetch_buffer.md
INST_PREFETCH_BUFFER -- requirements
Module: inst_prefetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queued instructions (power of two, >=2).
REQ-002 SHALL have parameter RESET_PC, default 32'h0, first fetch address after reset.
REQ-003 SHALL use one clock and an asynchronous, active-high reset; ports in order:
  clk  in  1  sole clock, rising edge
  reset  in  1  asynchronous, active-high reset
  redirect_valid  in  1  branch/jump resolved in decode; flush and refetch
  redirect_pc  in  32  new fetch address, valid with redirect_valid
  stall_d  in  1  decode stage stalled; head entry not consumed
  imem_req  out  1  fetch request
  imem_addr  out  32  word address of request
  imem_ready  in  1  memory accepts request this cycle
  imem_rvalid  in  1  response valid
  imem_rdata  in  32  fetched instruction
  instr_valid  out  1  head entry valid
  instr_out  out  32  head instruction; 32'h0 (NOP) when instr_valid=0
  pc_plus4_out  out  32  head address + 4; 32'h0 when instr_valid=0
  fifo_count  out  $clog2(DEPTH+1)  occupied entries

Function
REQ-004 SHALL accept a request on a cycle with imem_req=1 and imem_ready=1; at most one request outstanding.
REQ-005 SHALL drive imem_req = !redirect_valid && (!outstanding || imem_rvalid) && (fifo_count + outstanding < DEPTH).
REQ-006 SHALL hold imem_addr = fetch_pc; fetch_pc advances by 4 on each accepted request (32-bit wrap, 32'hFFFFFFFC -> 32'h0).
REQ-007 SHALL set outstanding on acceptance, clear on imem_rvalid; both same cycle leaves it set.
REQ-008 SHALL write {address+4, imem_rdata} into FIFO tail on imem_rvalid unless dropped per REQ-011/REQ-012; memory guarantees rvalid no earlier than 1 cycle after acceptance.
REQ-009 SHALL present the FIFO head registered; minimum latency imem_rvalid -> instr_valid is 1 cycle; no combinational bypass.
REQ-010 SHALL dequeue the head on every cycle with instr_valid=1 and stall_d=0; simultaneous enqueue and dequeue leaves fifo_count unchanged.
REQ-011 On redirect_valid: SHALL empty the FIFO, set fetch_pc = redirect_pc at the same edge, suppress imem_req that cycle, and drop any imem_rvalid that cycle.
REQ-012 On redirect_valid with outstanding=1 and imem_rvalid=0: SHALL set discard; next imem_rvalid dropped and discard cleared; no new request while discard=1.
REQ-013 Redirect SHALL override simultaneous dequeue and enqueue; instr_valid=0 the following cycle.
REQ-014 Full: fifo_count=DEPTH SHALL never overflow (guaranteed by REQ-005); stall_d with full FIFO holds all state.
REQ-015 Empty: stall_d ignored; instr_out/pc_plus4_out SHALL be 32'h0.
REQ-016 States: IDLE (no outstanding), WAIT (outstanding), DISCARD (outstanding, response dropped); transitions per REQ-007/REQ-012.

Reset
REQ-017 reset SHALL asynchronously set fetch_pc=RESET_PC, FIFO empty, outstanding=0, discard=0, instr_valid=0, instr_out=0, pc_plus4_out=0, fifo_count=0.
REQ-018 Reset mid-transaction SHALL abandon the outstanding request; a late imem_rvalid after reset release while state is IDLE SHALL be ignored.
REQ-019 First imem_req SHALL assert in the first cycle after reset deasserts, with imem_addr=RESET_PC.

Structure
REQ-020 Shared package SHALL hold RESET_PC default, NOP encoding 32'h0, fetch-entry type {pc_plus4[31:0], instr[31:0]}, state encoding.
REQ-021 Storage SHALL be one sub-module prefetch_fifo (synchronous, DEPTH entries, flush input); control in top.

Verification
REQ-022 Reset release, memory 1-cycle latency, stall_d=0 -> requests 0x0,0x4,0x8 back-to-back; instr_valid from cycle 3; pc_plus4_out 0x4,0x8,0xC.
REQ-023 stall_d=1 held 10 cycles -> fifo_count saturates at 4, imem_req=0, head stays pc_plus4_out=0x4; release drains 4 entries in order.
REQ-024 redirect_valid, redirect_pc=0x100 while outstanding to 0x8, response 3 cycles later -> response dropped, next request 0x100, next instr_valid shows pc_plus4_out=0x104.
REQ-025 redirect same cycle as imem_rvalid and dequeue -> fifo_count=0, instr_valid=0 next cycle, no dropped follow-up response.
REQ-026 RESET_PC=32'hFFFFFFF8 -> requests 0xFFFFFFF8,0xFFFFFFFC,0x0; pc_plus4_out 0xFFFFFFFC,0x0,0x4.
REQ-027 reset asserted while outstanding -> all outputs 0 immediately; post-reset stray imem_rvalid produces no instr_valid.
